uart_tx_scheduler: RTL

- Sequencer and arbiter in front of the UART transmitter.
- Shares one transmitter between two requesters:
  - register-file read path: 1 byte per request.
  - ALU result path: 2 bytes per request, sent LSB byte first.
- Drives the transmitter's parallel-data/valid inputs byte by byte and paces each byte on the transmitter's busy flag.
- Sits in the system-controller domain; tx_busy arrives already synchronized to CLK.

---
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the two requesters, the UART transmitter and
// uart_tx_scheduler. The scheduler connects through the slave modport; the
// requester/transmitter side connects through master.
interface uart_tx_scheduler_if #(
  parameter int WIDTH = 8
);
  logic               rf_rd_data_valid;
  logic [WIDTH-1:0]   rf_rd_data;
  logic               alu_out_valid;
  logic [2*WIDTH-1:0] alu_out;
  logic               rf_ack;
  logic               alu_ack;
  logic               tx_busy;
  logic [WIDTH-1:0]   tx_p_data;
  logic               tx_data_valid;
  logic               sched_busy;

  modport slave (
    input  rf_rd_data_valid, rf_rd_data, alu_out_valid, alu_out, tx_busy,
    output rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy
  );

  modport master (
    output rf_rd_data_valid, rf_rd_data, alu_out_valid, alu_out, tx_busy,
    input  rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between the register-file
// read path (1 byte per request) and the ALU result path (2 bytes, LSB first).
// Each byte is strobed once and paced on tx_busy; a strobe the transmitter
// never acknowledges with busy is re-sent after BUSY_WAIT_MAX cycles.
// Optional feature macro: UART_TX_SCHED_RR_EN selects round-robin arbitration;
// when undefined the register file always wins a simultaneous request.
//
// state   | meaning
// IDLE    | no frame in flight, arbitrating pending requests
// SEND    | byte presented, strobe issued on the way out
// WAIT_HI | waiting for the transmitter to raise busy (retry on timeout)
// WAIT_LO | transmitter shifting the byte, waiting for busy to drop
module uart_tx_scheduler #(
  parameter int WIDTH         = 8,
  parameter int BUSY_WAIT_MAX = 15
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_scheduler_if.slave bus
);
  localparam int CW = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_buf;
  logic               r_idx;
  logic               r_last_idx;
  logic [CW-1:0]      r_wait;
  logic               r_rf_ack;
  logic               r_alu_ack;
  logic [WIDTH-1:0]   r_tx_p_data;
  logic               r_tx_data_valid;
  logic               r_sched_busy;

  logic               w_grant_rf;
  logic               w_grant_alu;
  logic [WIDTH-1:0]   w_cur_byte;

`ifdef UART_TX_SCHED_RR_EN
  logic r_rr_alu_last;

  // Round-robin: on a tie, the side not granted last wins.
  always_comb begin
    w_grant_rf  = bus.rf_rd_data_valid && (!bus.alu_out_valid || r_rr_alu_last);
    w_grant_alu = bus.alu_out_valid && !w_grant_rf;
  end

  // Pointer remembers the side granted last; reset favours RF first.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_alu_last <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_grant_rf)       r_rr_alu_last <= 1'b0;
      else if (w_grant_alu) r_rr_alu_last <= 1'b1;
    end
  end
`else
  // Fixed priority: the register file always wins a tie.
  always_comb begin
    w_grant_rf  = bus.rf_rd_data_valid;
    w_grant_alu = bus.alu_out_valid && !w_grant_rf;
  end
`endif

  assign w_cur_byte = r_idx ? r_buf[2*WIDTH-1:WIDTH] : r_buf[WIDTH-1:0];

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state         <= S_IDLE;
      r_buf           <= '0;
      r_idx           <= 1'b0;
      r_last_idx      <= 1'b0;
      r_wait          <= '0;
      r_rf_ack        <= 1'b0;
      r_alu_ack       <= 1'b0;
      r_tx_p_data     <= '0;
      r_tx_data_valid <= 1'b0;
      r_sched_busy    <= 1'b0;
    end else begin
      r_rf_ack        <= 1'b0;
      r_alu_ack       <= 1'b0;
      r_tx_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_rf) begin
            r_buf        <= {{WIDTH{1'b0}}, bus.rf_rd_data};
            r_tx_p_data  <= bus.rf_rd_data;
            r_idx        <= 1'b0;
            r_last_idx   <= 1'b0;
            r_rf_ack     <= 1'b1;
            r_sched_busy <= 1'b1;
            r_state      <= S_SEND;
          end else if (w_grant_alu) begin
            r_buf        <= bus.alu_out;
            r_tx_p_data  <= bus.alu_out[WIDTH-1:0];
            r_idx        <= 1'b0;
            r_last_idx   <= 1'b1;
            r_alu_ack    <= 1'b1;
            r_sched_busy <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_data_valid <= 1'b1;
          r_wait          <= '0;
          r_state         <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_wait == WAIT_LAST) begin
            // Transmitter missed the strobe: present the same byte again.
            r_tx_p_data <= w_cur_byte;
            r_state     <= S_SEND;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (r_idx != r_last_idx) begin
              r_idx       <= 1'b1;
              r_tx_p_data <= r_buf[2*WIDTH-1:WIDTH];
              r_state     <= S_SEND;
            end else begin
              r_idx        <= 1'b0;
              r_sched_busy <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rf_ack        = r_rf_ack;
  assign bus.alu_ack       = r_alu_ack;
  assign bus.tx_p_data     = r_tx_p_data;
  assign bus.tx_data_valid = r_tx_data_valid;
  assign bus.sched_busy    = r_sched_busy;
endmodule
